// File: rtl/dm_sba_ctrl_if.sv
// dm_sba_ctrl_if: single-beat system bus port of the debug module SBA.
// master = SBA controller, slave = bus arbiter side.
interface dm_sba_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              sba_req_valid_o;
  logic              sba_req_ready_i;
  logic              sba_req_we_o;
  logic [ADDR_W-1:0] sba_req_addr_o;
  logic [2:0]        sba_req_size_o;
  logic [63:0]       sba_req_wdata_o;
  logic              sba_resp_valid_i;
  logic [63:0]       sba_resp_rdata_i;
  logic              sba_resp_err_i;

  modport master (
    output sba_req_valid_o, sba_req_we_o, sba_req_addr_o,
    output sba_req_size_o, sba_req_wdata_o,
    input  sba_req_ready_i, sba_resp_valid_i,
    input  sba_resp_rdata_i, sba_resp_err_i
  );

  modport slave (
    input  sba_req_valid_o, sba_req_we_o, sba_req_addr_o,
    input  sba_req_size_o, sba_req_wdata_o,
    output sba_req_ready_i, sba_resp_valid_i,
    output sba_resp_rdata_i, sba_resp_err_i
  );
endinterface

// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: debug module system bus access controller (SBCS/SBADDRESS0/SBDATA0/1).
// Define SBA_ACCESS64_EN for 64-bit accesses and a writable SBDATA1.
module dm_sba_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int SBVERSION = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmactive_i,
  input  logic          dmi_we_i,
  input  logic          dmi_re_i,
  input  logic [7:0]    dmi_addr_i,
  input  logic [31:0]   dmi_wdata_i,
  output logic [31:0]   dmi_rdata_o,
  dm_sba_ctrl_if.master sba,
  output logic          sbbusy_o
);

  localparam logic [7:0] A_SBCS    = 8'h38;
  localparam logic [7:0] A_SBADDR0 = 8'h39;
  localparam logic [7:0] A_SBDATA0 = 8'h3c;
  localparam logic [7:0] A_SBDATA1 = 8'h3d;

  localparam logic [2:0] SBA_IDLE       = 3'd0;
  localparam logic [2:0] SBA_READ       = 3'd1;
  localparam logic [2:0] SBA_WRITE      = 3'd2;
  localparam logic [2:0] SBA_WAIT_READ  = 3'd3;
  localparam logic [2:0] SBA_WAIT_WRITE = 3'd4;

`ifdef SBA_ACCESS64_EN
  localparam logic ACC64 = 1'b1;
`else
  localparam logic ACC64 = 1'b0;
`endif

  logic [2:0]        state;
  logic              busyerr;
  logic              readonaddr;
  logic              autoinc;
  logic              readondata;
  logic [2:0]        access;
  logic [2:0]        sberror;
  logic [ADDR_W-1:0] sbaddress;
  logic [31:0]       sbdata0;
  logic [31:0]       sbdata1;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [63:0]       req_wdata;
  logic [63:0]       rdata;
  logic [31:0]       sbcs;

  logic wr_cs, wr_addr, wr_d0, wr_d1, rd_d0;
  logic busy, gate, busy_hit;
  logic trig_ra, trig_wr, trig_rd, trig;
  logic size_ok, aligned;
  logic [ADDR_W-1:0] trig_addr;

  function automatic logic [63:0] fit(logic [63:0] d, logic [2:0] s);
    logic [63:0] r;
    unique case (s)
      3'd0:    r = {56'd0, d[7:0]};
      3'd1:    r = {48'd0, d[15:0]};
      3'd2:    r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign wr_cs   = dmi_we_i && dmi_addr_i == A_SBCS;
  assign wr_addr = dmi_we_i && dmi_addr_i == A_SBADDR0;
  assign wr_d0   = dmi_we_i && dmi_addr_i == A_SBDATA0;
  assign wr_d1   = dmi_we_i && dmi_addr_i == A_SBDATA1;
  assign rd_d0   = dmi_re_i && !dmi_we_i
                && dmi_addr_i == A_SBDATA0;

  assign busy     = state != SBA_IDLE;
  assign gate     = !busy && !busyerr && sberror == 3'd0;
  assign busy_hit = busy && (wr_addr || wr_d0 || wr_d1 || rd_d0);

  assign trig_ra = gate && wr_addr && readonaddr;
  assign trig_wr = gate && wr_d0;
  assign trig_rd = gate && rd_d0 && readondata;
  assign trig    = trig_ra || trig_wr || trig_rd;

  // read-on-address uses the address being written this cycle
  assign trig_addr = trig_ra ? ADDR_W'(dmi_wdata_i) : sbaddress;
  assign size_ok   = access <= (ACC64 ? 3'd3 : 3'd2);

  always_comb begin
    aligned = 1'b1;
    unique case (access)
      3'd1:    aligned = !trig_addr[0];
      3'd2:    aligned = trig_addr[1:0] == 2'd0;
      3'd3:    aligned = trig_addr[2:0] == 3'd0;
      default: aligned = 1'b1;
    endcase
  end

  assign rdata = fit(sba.sba_resp_rdata_i, req_size);

`ifndef SBA_ACCESS64_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata[63:32];
  assign sbdata1      = '0;
`endif

  assign sbcs = {3'(SBVERSION), 6'd0, busyerr, busy,
                 readonaddr, access, autoinc, readondata,
                 sberror, 7'(ADDR_W), 1'b0, ACC64, 3'b111};

  always_comb begin
    dmi_rdata_o = '0;
    unique case (1'b1)
      dmi_addr_i == A_SBCS:    dmi_rdata_o = sbcs;
      dmi_addr_i == A_SBADDR0: dmi_rdata_o = 32'(sbaddress);
      dmi_addr_i == A_SBDATA0: dmi_rdata_o = sbdata0;
      dmi_addr_i == A_SBDATA1: dmi_rdata_o = sbdata1;
      default:                 dmi_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SBA_IDLE;
      busyerr    <= 1'b0;
      readonaddr <= 1'b0;
      autoinc    <= 1'b0;
      readondata <= 1'b0;
      access     <= 3'd2;
      sberror    <= 3'd0;
      sbaddress  <= '0;
      sbdata0    <= '0;
`ifdef SBA_ACCESS64_EN
      sbdata1    <= '0;
`endif
      req_addr   <= '0;
      req_size   <= '0;
      req_wdata  <= '0;
    end else if (!dmactive_i) begin
      state      <= SBA_IDLE;
      busyerr    <= 1'b0;
      readonaddr <= 1'b0;
      autoinc    <= 1'b0;
      readondata <= 1'b0;
      access     <= 3'd2;
      sberror    <= 3'd0;
      sbaddress  <= '0;
      sbdata0    <= '0;
`ifdef SBA_ACCESS64_EN
      sbdata1    <= '0;
`endif
      req_addr   <= '0;
      req_size   <= '0;
      req_wdata  <= '0;
    end else begin
      if (wr_cs) begin
        if (dmi_wdata_i[22]) busyerr <= 1'b0;
        sberror    <= sberror & ~dmi_wdata_i[14:12];
        readonaddr <= dmi_wdata_i[20];
        access     <= dmi_wdata_i[19:17];
        autoinc    <= dmi_wdata_i[16];
        readondata <= dmi_wdata_i[15];
      end
      if (busy_hit) busyerr <= 1'b1;
      if (!busy && wr_addr) sbaddress <= ADDR_W'(dmi_wdata_i);
      if (!busy && wr_d0) sbdata0 <= dmi_wdata_i;
`ifdef SBA_ACCESS64_EN
      if (!busy && wr_d1) sbdata1 <= dmi_wdata_i;
`endif
      if (trig) begin
        if (!size_ok) begin
          sberror <= 3'd4;
        end else if (!aligned) begin
          sberror <= 3'd3;
        end else begin
          state     <= trig_wr ? SBA_WRITE : SBA_READ;
          req_addr  <= trig_addr;
          req_size  <= access;
          req_wdata <= trig_wr
                     ? fit({sbdata1, dmi_wdata_i}, access)
                     : 64'd0;
        end
      end
      unique case (state)
        SBA_READ:
          if (sba.sba_req_ready_i) state <= SBA_WAIT_READ;
        SBA_WRITE:
          if (sba.sba_req_ready_i) state <= SBA_WAIT_WRITE;
        SBA_WAIT_READ, SBA_WAIT_WRITE:
          if (sba.sba_resp_valid_i) begin
            state <= SBA_IDLE;
            if (sba.sba_resp_err_i) begin
              sberror <= 3'd2;
            end else begin
              if (state == SBA_WAIT_READ) begin
                sbdata0 <= rdata[31:0];
`ifdef SBA_ACCESS64_EN
                sbdata1 <= rdata[63:32];
`endif
              end
              if (autoinc)
                sbaddress <= sbaddress + (ADDR_W'(1) << req_size);
            end
          end
        default: ;
      endcase
    end
  end

  assign sba.sba_req_valid_o = state == SBA_READ || state == SBA_WRITE;
  assign sba.sba_req_we_o    = state == SBA_WRITE;
  assign sba.sba_req_addr_o  = req_addr;
  assign sba.sba_req_size_o  = req_size;
  assign sba.sba_req_wdata_o = req_wdata;
  assign sbbusy_o            = busy;

endmodule

// File: doc/dm_sba_ctrl.md
Name: dm_sba_ctrl

Overview:
- System Bus Access (SBA) controller for the debug module.
- Owns the SBCS, SBADDRESS0, SBDATA0 and SBDATA1 registers.
- Decodes DMI register reads and writes into single-beat bus master transactions, using the SBA_IDLE/READ/WRITE/WAIT_READ/WAIT_WRITE sequence.
- Sits between the DMI register decoder and the system bus arbiter; gives the debugger memory access without halting a hart.

Parameters:
- ADDR_W, 32: bus address width; reported in sbcs.sbasize.
- SBVERSION, 1: value of sbcs.sbversion.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- dmactive_i  input  1  DM active; 0 synchronously clears the block
- dmi_we_i  input  1  DMI register write strobe
- dmi_re_i  input  1  DMI register read strobe
- dmi_addr_i  input  8  DM register address (dm_csr_e encoding)
- dmi_wdata_i  input  32  DMI write data
- dmi_rdata_o  output  32  combinational read mux: SBCS, SBADDRESS0, SBDATA0, SBDATA1; all other addresses return 0
- sba_req_valid_o  output  1  bus request valid
- sba_req_ready_i  input  1  bus request accepted
- sba_req_we_o  output  1  1 = write
- sba_req_addr_o  output  ADDR_W  byte address
- sba_req_size_o  output  3  log2 of access bytes (equals sbaccess)
- sba_req_wdata_o  output  64  right-justified write data, masked to size
- sba_resp_valid_i  input  1  response valid
- sba_resp_rdata_i  input  64  right-justified read data
- sba_resp_err_i  input  1  bus error
- sbbusy_o  output  1  equals sbcs.sbbusy

Behaviour:
- Reset (rst, or dmactive_i=0):
  - state = SBA_IDLE.
  - sbaddress = 0, sbdata = 0.
  - sbcs writable fields = 0, except sbaccess = 2.
  - All outputs 0.
- dmactive_i=0 mid-transaction: request is withdrawn next cycle; a late response is ignored.
- SBCS writes:
  - sbbusyerror (bit 22) and sberror (bits 14:12) are write-1-to-clear.
  - sbreadonaddr, sbaccess, sbautoincrement and sbreadondata are plain R/W.
  - Read-only fields: sbversion, sbasize, sbaccess8/16/32 = 1, sbaccess128 = 0.
- Access triggers, each sampled on the DMI strobe in cycle N:
  - Write to SBADDRESS0 with sbreadonaddr=1: read.
  - Write to SBDATA0: write.
  - Read of SBDATA0 with sbreadondata=1: read. The read returns the pre-access value.
- Trigger gating:
  - No trigger starts while sberror != 0 or sbbusyerror = 1. Register writes still take effect.
- Busy state (state != SBA_IDLE):
  - Any write to SBADDRESS0, SBDATA0 or SBDATA1, or any read of SBDATA0, sets sbbusyerror.
  - That write is discarded and no new trigger starts.
- Checks at trigger time, in this order; failure means no bus request:
  - Unsupported sbaccess: sberror = 4.
  - Address not aligned to 2^sbaccess: sberror = 3.
- Sequence:
  - IDLE goes to READ or WRITE in cycle N+1; sba_req_valid_o is asserted from N+1.
  - Valid, address, size and data are held stable until sba_req_ready_i.
  - On the ready cycle: go to WAIT_READ or WAIT_WRITE.
  - On sba_resp_valid_i: go to IDLE.
  - sbbusy_o = 1 for all non-IDLE states.
  - Minimum: ready in N+1, response in N+2, IDLE in N+3.
- Completion:
  - Read: {sbdata1, sbdata0} = rdata masked to size (upper bits zero).
  - Autoincrement: if sbautoincrement=1, sbaddress += 2^sbaccess, wrapping modulo 2^ADDR_W.
  - Bus error: sberror = 2; data and address are left unchanged.
- A response received in IDLE is ignored.
- dmi_we_i and dmi_re_i high together: the write is processed; the read produces no trigger.

Optional Feature:
- Macro: SBA_ACCESS64_EN.
- Defined:
  - sbaccess64 = 1.
  - SBDATA1 is R/W and supplies wdata[63:32].
  - sbaccess = 3 is legal.
- Undefined:
  - sbaccess64 = 0.
  - SBDATA1 reads 0 and ignores writes.
  - sbaccess = 3 produces sberror = 4.
  - sba_req_wdata_o[63:32] = 0.

Test Plan:
- 32-bit write: sbaccess=2; SBADDRESS0=0x8000_0000; SBDATA0=0xDEADBEEF -> next cycle valid=1, we=1, addr=0x8000_0000, size=2, wdata=0xDEADBEEF; with ready and response immediate, sbbusy is high for 2 cycles.
- Read-on-address with autoincrement: SBCS=0x0015_0000; SBADDRESS0=0x1000 -> read request; resp 0x12345678 -> SBDATA0=0x12345678, SBADDRESS0=0x1004.
- Busy error: hold ready=0 and write SBDATA0 twice -> one request, sbbusyerror=1; after completion a further SBDATA0 write issues nothing until SBCS bit 22 is written 1.
- Misaligned access: sbaccess=2, readonaddr, SBADDRESS0=0x1002 -> sberror=3, no request. Bus error: resp_err=1 -> sberror=2, address unchanged.
- Read-on-data: SBDATA0=0xAA and sbreadondata=1 -> read of SBDATA0 returns 0xAA and triggers a read at the current address; resp 0x55 -> SBDATA0=0x55.
- Feature and abort:
  - With SBA_ACCESS64_EN: sbaccess=3, SBDATA1=0x1, SBDATA0=0x2 -> wdata=0x0000_0001_0000_0002.
  - Without it: same stimulus -> sberror=4.
  - dmactive_i=0 in WAIT_READ -> IDLE next cycle, registers cleared, later response ignored.
